// File: rtl/orb_pkg.sv
// Shared constants and types for the orbit frame synchroniser.
package orb_pkg;

    localparam int WORD_W  = 12;
    localparam int PHR_W   = 5;
    localparam int IDX_W   = 11;
    localparam int GRP_W   = 5;
    localparam int SLIP_W  = 8;
    localparam int FRAME_W = 7;
    localparam int HIST_W  = 32;
    localparam int GSLOT_W = 64;
    localparam int MISS_W  = 2;

    // Marker pattern over one phrase; bit p is the marker expected at phrase position p.
    localparam logic [HIST_W-1:0]  PHR_MASK = 32'h4504_0154;
    // Position 16 carries the group-slot bit, so it is ignored for phrase matching.
    localparam logic [HIST_W-1:0]  PHR_CARE = 32'hFFFE_FFFF;

    // Group-slot patterns over 64 phrases; bit n is the slot marker of phrase n.
    localparam logic [GSLOT_W-1:0] GRP_NORM = 64'h4E00_0000_0000_0000;
    localparam logic [GSLOT_W-1:0] GRP_LAST = 64'hB100_0000_0000_0000;
    // Phrase 7 carries the frame marker and is ignored for group matching.
    localparam logic [GSLOT_W-1:0] GRP_CARE = 64'hFFFF_FFFF_FFFF_FF7F;

    localparam logic [PHR_W-1:0]   PHR_GSLOT_POS = 5'd16;
    localparam logic [PHR_W-1:0]   PHR_LAST_POS  = 5'd31;
    localparam logic [IDX_W-1:0]   IDX_LAST      = 11'd2047;
    localparam logic [GRP_W-1:0]   GRP_LAST_NUM  = 5'd31;
    localparam logic [MISS_W-1:0]  FLY_LIMIT     = 2'd3;
    localparam int                 FRAME_SLOT    = 7;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_PHR  = 2'd1,
        ST_GRP  = 2'd2
    } orb_state_e;

endpackage

// File: rtl/orb_pat_match.sv
// Masked pattern comparator: matches when every cared-for bit of data equals the pattern.
module orb_pat_match #(
    parameter int W = 32
) (
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] pattern_i,
    input  logic [W-1:0] care_i,
    output logic         match_o
);

    assign match_o = (((data_i ^ pattern_i) & care_i) == '0);

endmodule

// File: rtl/orb_frame_sync.sv
// Orbit frame synchroniser: finds phrase alignment from word markers, then group
// alignment from the phrase-position-16 slot markers, with a 3-phrase flywheel.
// Optional frame counter output oFrame is built when ORB_FRAME_SYNC_FRAME_EN is defined.
module orb_frame_sync
    import orb_pkg::*;
(
    input  logic               iClkOrb,
    input  logic               reset,
    input  logic [WORD_W-1:0]  iWord,
    input  logic               iVal,
    output logic [WORD_W-1:0]  oWord,
    output logic               oVal,
    output logic [1:0]         oState,
    output logic [PHR_W-1:0]   oPhrase,
    output logic [IDX_W-1:0]   oWrdIdx,
    output logic [GRP_W-1:0]   oGroup,
    output logic               oGrpVal,
    output logic               oErr,
    output logic [SLIP_W-1:0]  oSlips
`ifdef ORB_FRAME_SYNC_FRAME_EN
    ,
    output logic [FRAME_W-1:0] oFrame
`endif
);

    orb_state_e          state_q, state_d;
    logic                locked, in_grp;

    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [GSLOT_W-1:0]  gslot_q, gslot_d;
    logic [PHR_W-1:0]    phr_q, phr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic                grpval_q, grpval_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                pbad_q, pbad_d;
    logic [SLIP_W-1:0]   slips_q, slips_d;
    logic [WORD_W-1:0]   word_q;
    logic                val_q, err_q;

    logic                mk;
    logic [HIST_W-1:0]   hist_sh;
    logic [GSLOT_W-1:0]  gslot_sh;
    logic [PHR_W-1:0]    phr_nx;
    logic [IDX_W-1:0]    idx_nx;
    logic [GRP_W-1:0]    grp_cur;
    logic [MISS_W-1:0]   miss_inc;
    logic                pos16, end_phr, mk_err;
    logic                grp_end, grp_wrap, grp_eval, grp_hit, grp_miss, grp_dup_err;
    logic                phr_hit, norm_hit, last_hit;
    logic                phrase_bad, slip;

    // Phrase match on the history including the current word's marker.
    orb_pat_match #(.W(HIST_W)) u_phr_match (
        .data_i    (hist_sh),
        .pattern_i (PHR_MASK),
        .care_i    (PHR_CARE),
        .match_o   (phr_hit)
    );

    orb_pat_match #(.W(GSLOT_W)) u_norm_match (
        .data_i    (gslot_sh),
        .pattern_i (GRP_NORM),
        .care_i    (GRP_CARE),
        .match_o   (norm_hit)
    );

    orb_pat_match #(.W(GSLOT_W)) u_last_match (
        .data_i    (gslot_sh),
        .pattern_i (GRP_LAST),
        .care_i    (GRP_CARE),
        .match_o   (last_hit)
    );

    // Decode what the current word means for phrase, group and flywheel tracking.
    always_comb begin
        mk          = iWord[WORD_W-1];
        hist_sh     = {mk, hist_q[HIST_W-1:1]};
        phr_nx      = phr_q + 5'd1;
        idx_nx      = idx_q + 11'd1;
        pos16       = locked && (phr_nx == PHR_GSLOT_POS);
        gslot_sh    = pos16 ? {mk, gslot_q[GSLOT_W-1:1]} : gslot_q;
        end_phr     = locked && (phr_nx == PHR_LAST_POS);
        mk_err      = locked && (phr_nx != PHR_GSLOT_POS) && (mk != PHR_MASK[phr_nx]);
        grp_end     = in_grp && (idx_nx == IDX_LAST);
        grp_wrap    = in_grp && (idx_nx == '0);
        grp_cur     = grp_wrap ? grp_q + 5'd1 : grp_q;
        grp_hit     = norm_hit | last_hit;
        // Before group lock every phrase end is a candidate; afterwards only the group end.
        grp_eval    = ((state_q == ST_PHR) && end_phr) || grp_end;
        grp_miss    = grp_end && !grp_hit;
        grp_dup_err = grp_eval && norm_hit && grpval_q && (grp_cur == GRP_LAST_NUM);
        phrase_bad  = pbad_q | mk_err | grp_miss;
        miss_inc    = miss_q + 2'd1;
        slip        = end_phr && phrase_bad && (miss_inc == FLY_LIMIT);
    end

    // State register.
    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) state_q <= ST_HUNT;
        else        state_q <= state_d;
    end

    // Next-state logic, advanced only on accepted words.
    always_comb begin
        state_d = state_q;
        if (iVal) begin
            case (state_q)
                ST_HUNT: if (phr_hit) state_d = ST_PHR;
                ST_PHR: begin
                    if (slip)                    state_d = ST_HUNT;
                    else if (end_phr && grp_hit) state_d = ST_GRP;
                end
                ST_GRP:  if (slip) state_d = ST_HUNT;
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // State-derived outputs and qualifiers.
    always_comb begin
        locked = (state_q != ST_HUNT);
        in_grp = (state_q == ST_GRP);
        oState = state_q;
    end

    // Next values of the tracking registers.
    always_comb begin
        hist_d   = hist_q;
        gslot_d  = gslot_q;
        phr_d    = phr_q;
        idx_d    = idx_q;
        grp_d    = grp_q;
        grpval_d = grpval_q;
        miss_d   = miss_q;
        pbad_d   = pbad_q;
        slips_d  = slips_q;
        if (iVal) begin
            hist_d = hist_sh;
            if (!locked) begin
                if (phr_hit) begin
                    phr_d  = PHR_LAST_POS;
                    miss_d = '0;
                    pbad_d = 1'b0;
                end
            end else begin
                phr_d   = phr_nx;
                gslot_d = gslot_sh;
                if (in_grp) begin
                    idx_d = idx_nx;
                    grp_d = grp_cur;
                end
                if (grp_eval && grp_hit) begin
                    idx_d = IDX_LAST;
                    if (last_hit) begin
                        grp_d    = GRP_LAST_NUM;
                        grpval_d = 1'b1;
                    end
                end
                if (end_phr) begin
                    pbad_d = 1'b0;
                    miss_d = phrase_bad ? miss_inc : '0;
                end else begin
                    pbad_d = phrase_bad;
                end
                // Lock loss: forget group history so a relock starts from a clean slate.
                if (slip) begin
                    gslot_d  = '0;
                    miss_d   = '0;
                    grpval_d = 1'b0;
                    slips_d  = (slips_q == '1) ? slips_q : slips_q + 8'd1;
                end
            end
        end
    end

    // Tracking and output registers.
    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            hist_q   <= '0;
            gslot_q  <= '0;
            phr_q    <= '0;
            idx_q    <= '0;
            grp_q    <= '0;
            grpval_q <= 1'b0;
            miss_q   <= '0;
            pbad_q   <= 1'b0;
            slips_q  <= '0;
            word_q   <= '0;
            val_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            gslot_q  <= gslot_d;
            phr_q    <= phr_d;
            idx_q    <= idx_d;
            grp_q    <= grp_d;
            grpval_q <= grpval_d;
            miss_q   <= miss_d;
            pbad_q   <= pbad_d;
            slips_q  <= slips_d;
            val_q    <= iVal;
            err_q    <= iVal & (mk_err | grp_dup_err);
            if (iVal) word_q <= iWord;
        end
    end

`ifdef ORB_FRAME_SYNC_FRAME_EN
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               fzero_q, fzero_d;

    // Frame counter: steps at the group 31->0 wrap, or restarts at 0 when the last
    // group carried the frame-0 marker in phrase 7.
    always_comb begin
        frame_d = frame_q;
        fzero_d = fzero_q;
        if (iVal) begin
            if (grp_eval && last_hit && !slip) fzero_d = gslot_sh[FRAME_SLOT];
            if (grp_wrap && (grp_q == GRP_LAST_NUM)) begin
                frame_d = fzero_q ? '0 : frame_q + 7'd1;
                fzero_d = 1'b0;
            end
        end
    end

    // Frame counter registers.
    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            frame_q <= '0;
            fzero_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            fzero_q <= fzero_d;
        end
    end

    assign oFrame = frame_q;
`endif

    assign oWord   = word_q;
    assign oVal    = val_q;
    assign oPhrase = phr_q;
    assign oWrdIdx = idx_q;
    assign oGroup  = grp_q;
    assign oGrpVal = grpval_q;
    assign oErr    = err_q;
    assign oSlips  = slips_q;

endmodule
